// File: rtl/dmux_lane_if.sv
// Handshake and DMUXS-facing bundle for dmux_lane_sequencer.
// slave = sequencer side, master = word source / DMUXS capture side.
interface dmux_lane_if #(
    parameter int unsigned N    = 98,
    parameter int unsigned CNTW = 16
) ();
    logic [N-1:0]    in_data;
    logic            in_valid;
    logic            in_sof;
    logic            in_ready;
    logic            out_ready;
    logic [N-1:0]    dm_in;
    logic            dm_s1;
    logic            dm_s2;
    logic            out_valid;
    logic [3:0]      out_we;
    logic            frame_done;
    logic [CNTW-1:0] frame_cnt;

    modport slave (
        input  in_data, in_valid, in_sof, out_ready,
        output in_ready, dm_in, dm_s1, dm_s2, out_valid, out_we, frame_done, frame_cnt
    );

    modport master (
        output in_data, in_valid, in_sof, out_ready,
        input  in_ready, dm_in, dm_s1, dm_s2, out_valid, out_we, frame_done, frame_cnt
    );
endinterface

// File: rtl/dmux_lane_sequencer.sv
// Round-robin lane sequencer feeding a DMUXS 1-to-4 demux, one registered word slot.
// Optional sticky framing-error flag sof_err when DMUX_SOF_ERR_EN is defined.
module dmux_lane_sequencer #(
    parameter int unsigned N    = 98,
    parameter int unsigned CNTW = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    dmux_lane_if.slave bus
`ifdef DMUX_SOF_ERR_EN
    ,
    output logic      sof_err
`endif
);
    localparam int unsigned LW = 2;

    typedef enum logic [LW-1:0] {
        LANE_A = 2'd0,
        LANE_B = 2'd1,
        LANE_C = 2'd2,
        LANE_D = 2'd3
    } lane_e;

    lane_e           lane_q;
    lane_e           lane_d;
    lane_e           word_lane;

    logic [N-1:0]    data_q;
    logic [LW-1:0]   sel_q;
    logic            valid_q;
    logic [CNTW-1:0] cnt_q;

    logic            in_ready_c;
    logic            accept_c;
    logic            out_hs_c;
    logic            frame_done_c;

    // Single output slot: free when empty or when its word leaves this cycle.
    assign in_ready_c   = !valid_q || bus.out_ready;
    assign accept_c     = bus.in_valid && in_ready_c;
    assign out_hs_c     = valid_q && bus.out_ready;
    assign frame_done_c = out_hs_c && (sel_q == LW'(LANE_D));

    // Lane state register: lane the next accepted word will take.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q <= LANE_A;
        end else begin
            lane_q <= lane_d;
        end
    end

    // Next-lane logic; in_sof restarts the frame at lane A.
    always_comb begin
        lane_d    = lane_q;
        word_lane = lane_q;
        if (bus.in_sof) begin
            word_lane = LANE_A;
        end
        if (accept_c) begin
            lane_d = lane_e'(LW'(word_lane) + LW'(1));
        end
    end

    // Output word slot towards DMUXS; selects persist between transfers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
        end else if (accept_c) begin
            data_q  <= bus.in_data;
            sel_q   <= LW'(word_lane);
            valid_q <= 1'b1;
        end else if (out_hs_c) begin
            valid_q <= 1'b0;
        end
    end

    // Completed-frame counter, wraps naturally at 2^CNTW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (frame_done_c) begin
            cnt_q <= cnt_q + CNTW'(1);
        end
    end

`ifdef DMUX_SOF_ERR_EN
    logic wrapped_q;

    // wrapped_q marks lane A reached by finishing a frame (not by reset).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrapped_q <= 1'b0;
            sof_err   <= 1'b0;
        end else if (accept_c) begin
            wrapped_q <= (word_lane == LANE_D);
            if (bus.in_sof && (lane_q != LANE_A)) begin
                sof_err <= 1'b1;
            end
            if (!bus.in_sof && (lane_q == LANE_A) && wrapped_q) begin
                sof_err <= 1'b1;
            end
        end
    end
`endif

    assign bus.in_ready   = in_ready_c;
    assign bus.dm_in      = data_q;
    assign bus.dm_s1      = sel_q[0];
    assign bus.dm_s2      = sel_q[1];
    assign bus.out_valid  = valid_q;
    assign bus.out_we     = {4{out_hs_c}} & (4'b0001 << sel_q);
    assign bus.frame_done = frame_done_c;
    assign bus.frame_cnt  = cnt_q;

endmodule

// File: tb/tb_dmux_lane_sequencer.sv
// Directed + randomized bench for dmux_lane_sequencer against a frame-position model.
module tb_dmux_lane_sequencer;
    localparam int unsigned N    = 98;
    localparam int unsigned CNTW = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    // Reference model: pending word, frame position of next word, frame count.
    bit           m_valid;
    logic [N-1:0] m_data;
    int           m_lane;
    int           m_pos;
    int           m_frames;
    bit           m_wrapped;
    bit           m_err;

    dmux_lane_if #(.N(N), .CNTW(CNTW)) bus ();

`ifdef DMUX_SOF_ERR_EN
    logic sof_err;
`endif

    dmux_lane_sequencer #(.N(N), .CNTW(CNTW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef DMUX_SOF_ERR_EN
        ,
        .sof_err (sof_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid   = 1'b0;
        m_data    = '0;
        m_lane    = 0;
        m_pos     = 0;
        m_frames  = 0;
        m_wrapped = 1'b0;
        m_err     = 1'b0;
    endtask

    // One clock cycle: drive, check mid-cycle, advance the model at the edge.
    task automatic step(input bit v, input bit sof, input logic [N-1:0] d, input bit r);
        bit exp_ready;
        bit hs;
        bit acc;
        int lane;
        bus.in_valid  = v;
        bus.in_sof    = sof;
        bus.in_data   = d;
        bus.out_ready = r;
        exp_ready = !m_valid || r;
        hs        = m_valid && r;
        acc       = v && exp_ready;
        @(negedge clk);
        chk("in_ready", 128'(bus.in_ready), 128'(exp_ready));
        chk("out_valid", 128'(bus.out_valid), 128'(m_valid));
        chk("dm_in", 128'(bus.dm_in), 128'(m_data));
        chk("sel", 128'({bus.dm_s2, bus.dm_s1}), 128'(m_lane));
        chk("out_we", 128'(bus.out_we), hs ? 128'(1) << m_lane : 128'(0));
        chk("frame_done", 128'(bus.frame_done), 128'(hs && m_lane == 3));
        chk("frame_cnt", 128'(bus.frame_cnt), 128'(m_frames));
`ifdef DMUX_SOF_ERR_EN
        chk("sof_err", 128'(sof_err), 128'(m_err));
`endif
        @(posedge clk);
        if (hs && m_lane == 3) m_frames = (m_frames + 1) % (1 << CNTW);
        if (acc) begin
            if (sof && m_pos != 0) m_err = 1'b1;
            if (!sof && m_pos == 0 && m_wrapped) m_err = 1'b1;
            lane      = sof ? 0 : m_pos;
            m_wrapped = (lane == 3);
            m_pos     = (lane + 1) % 4;
            m_valid   = 1'b1;
            m_data    = d;
            m_lane    = lane;
        end else if (hs) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    function automatic logic [N-1:0] rnd_word();
        return N'({$urandom, $urandom, $urandom, $urandom});
    endfunction

    initial begin
        int saved_frames;
        checks = 0;
        errors = 0;
        model_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sof    = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Reset values while rst_n is held.
        #12;
        chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_dm_in", 128'(bus.dm_in), 128'(0));
        chk("rst_sel", 128'({bus.dm_s2, bus.dm_s1}), 128'(0));
        chk("rst_frame_cnt", 128'(bus.frame_cnt), 128'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // First frame 4532..4535 at full rate.
        step(1'b1, 1'b1, N'(4532), 1'b1);
        for (int i = 1; i < 4; i++) step(1'b1, 1'b0, N'(4532 + i), 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        chk("first_frame_cnt", 128'(bus.frame_cnt), 128'(1));

        // Backpressure: one word held for 5 cycles, then release with a follower.
        step(1'b1, 1'b1, rnd_word(), 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, rnd_word(), 1'b0);
        step(1'b1, 1'b0, N'(77), 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);

        // Abandoned partial frame: A, B, then in_sof with 7.
        step(1'b1, 1'b1, N'(1), 1'b1);
        step(1'b1, 1'b0, N'(2), 1'b1);
        saved_frames = m_frames;
        step(1'b1, 1'b1, N'(7), 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        chk("abandon_frame_cnt", 128'(bus.frame_cnt), 128'(saved_frames));

        // 2^CNTW frames back to back; counter wraps and in_ready never drops.
        for (int i = 0; i < 4 * (1 << CNTW); i++) begin
            step(1'b1, (i % 4) == 0, rnd_word(), 1'b1);
            chk("wrap_in_ready", 128'(bus.in_ready), 128'(1));
        end
        step(1'b0, 1'b0, '0, 1'b1);

        // Asynchronous reset mid-frame with a word pending.
        step(1'b1, 1'b1, rnd_word(), 1'b1);
        step(1'b1, 1'b0, rnd_word(), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("arst_dm_in", 128'(bus.dm_in), 128'(0));
        chk("arst_sel", 128'({bus.dm_s2, bus.dm_s1}), 128'(0));
        chk("arst_out_we", 128'(bus.out_we), 128'(0));
        chk("arst_frame_cnt", 128'(bus.frame_cnt), 128'(0));
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 1'b0, N'(55), 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);

        // Random gaps, backpressure and occasional frame restarts.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
                 rnd_word(), $urandom_range(0, 9) < 7);
        end
        step(1'b0, 1'b0, '0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
